// File: rtl/shift_rx_pkg.sv
// Shared types and sizing helpers for the three-wire serial receiver.
package shift_rx_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_e;

  localparam int DEFAULT_N           = 8;
  localparam int DEFAULT_SYNC_STAGES = 2;

  // Bit counter must hold 0..N+1 so that an overlong frame is distinguishable from N.
  function automatic int cntWidth(input int n);
    return $clog2(n + 2);
  endfunction

endpackage

// File: rtl/shift_rx_sync_edge.sv
// Multi-flop synchroniser for one asynchronous pin, with a rising-edge event output.
module sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic CLK,
  input  logic RSTN,
  input  logic d,
  output logic q,
  output logic rise
);

  logic [SYNC_STAGES-1:0] stages_q;
  logic                   prev_q;

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      stages_q <= '0;
      prev_q   <= 1'b0;
    end else begin
      stages_q <= {stages_q[SYNC_STAGES-2:0], d};
      prev_q   <= stages_q[SYNC_STAGES-1];
    end
  end

  assign q    = stages_q[SYNC_STAGES-1];
  assign rise = q & ~prev_q;

endmodule

// File: rtl/shift_rx.sv
// 74HC595-style serial-in/parallel-out receiver: synchronises SCK/SDI/SLATCH and
// assembles N-bit words, flagging wrong bit counts and aborting stalled frames.
module shift_rx
  import shift_rx_pkg::*;
#(
  parameter int N           = DEFAULT_N,
  parameter int SYNC_STAGES = DEFAULT_SYNC_STAGES,
  parameter int TIMEOUT     = 65536
) (
  input  logic         CLK,
  input  logic         RSTN,
  input  logic         SCK,
  input  logic         SDI,
  input  logic         SLATCH,
  output logic [N-1:0] DATA,
  output logic         VALID,
  output logic         FRAME_ERR,
  output logic         ABORT,
  output logic         BUSY
);

  localparam int CW = cntWidth(N);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic sckRise, sckLevelUnused;
  logic sdiS, sdiRiseUnused;
  logic latchRise, latchLevelUnused;

  state_e         state_q, state_d;
  logic [N-1:0]   shreg_q, shreg_d;
  logic [CW-1:0]  cnt_q, cnt_d, cntShift;
  logic [TW-1:0]  tcnt_q, tcnt_d;
  logic [N-1:0]   data_q, data_d;
  logic           valid_q, valid_d;
  logic           frameErr_q, frameErr_d;
  logic           abort_q, abort_d;
  logic           busy_q, busy_d;
  logic           timeoutHit;

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncSck (
    .CLK(CLK), .RSTN(RSTN), .d(SCK), .q(sckLevelUnused), .rise(sckRise)
  );

  // SDI shares SCK's stage depth so the sampled bit lines up with the SCK rise event.
  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncSdi (
    .CLK(CLK), .RSTN(RSTN), .d(SDI), .q(sdiS), .rise(sdiRiseUnused)
  );

  sync_edge #(.SYNC_STAGES(SYNC_STAGES)) uSyncLatch (
    .CLK(CLK), .RSTN(RSTN), .d(SLATCH), .q(latchLevelUnused), .rise(latchRise)
  );

  assign timeoutHit = (state_q == SHIFT) && !sckRise && (tcnt_q == TW'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (latchRise || timeoutHit) begin
      state_d = IDLE;
    end else if (sckRise) begin
      state_d = SHIFT;
    end
  end

  // A shift in the same cycle as a latch is applied first, so the latch sees it.
  always_comb begin
    shreg_d    = sckRise ? {shreg_q[N-2:0], sdiS} : shreg_q;
    cntShift   = (sckRise && (cnt_q != CW'(N + 1))) ? cnt_q + 1'b1 : cnt_q;
    cnt_d      = cntShift;
    tcnt_d     = ((state_q == SHIFT) && !sckRise) ? tcnt_q + 1'b1 : '0;
    data_d     = data_q;
    frameErr_d = frameErr_q;
    valid_d    = 1'b0;
    abort_d    = 1'b0;
    if (latchRise) begin
      data_d     = shreg_d;
      valid_d    = 1'b1;
      frameErr_d = (cntShift != CW'(N));
      cnt_d      = '0;
      tcnt_d     = '0;
    end else if (timeoutHit) begin
      abort_d = 1'b1;
      cnt_d   = '0;
      tcnt_d  = '0;
    end
    busy_d = (state_d == SHIFT);
  end

  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      shreg_q    <= '0;
      cnt_q      <= '0;
      tcnt_q     <= '0;
      data_q     <= '0;
      valid_q    <= 1'b0;
      frameErr_q <= 1'b0;
      abort_q    <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      shreg_q    <= shreg_d;
      cnt_q      <= cnt_d;
      tcnt_q     <= tcnt_d;
      data_q     <= data_d;
      valid_q    <= valid_d;
      frameErr_q <= frameErr_d;
      abort_q    <= abort_d;
      busy_q     <= busy_d;
    end
  end

  assign DATA      = data_q;
  assign VALID     = valid_q;
  assign FRAME_ERR = frameErr_q;
  assign ABORT     = abort_q;
  assign BUSY      = busy_q;

endmodule

// File: tb/tb_shift_rx.sv
// Directed self-checking bench for shift_rx; pins are driven on the falling clock edge.
module tb_shift_rx;

  logic       CLK = 1'b0;
  logic       RSTN = 1'b0;
  logic       SCK = 1'b0;
  logic       SDI = 1'b0;
  logic       SLATCH = 1'b0;
  logic [7:0] DATA;
  logic       VALID, FRAME_ERR, ABORT, BUSY;

  int checkCount = 0;
  int passCount  = 0;
  int validCount = 0;
  int abortCount = 0;
  int overlapCount = 0;

  shift_rx #(.N(8), .SYNC_STAGES(2), .TIMEOUT(16)) dut (
    .CLK(CLK), .RSTN(RSTN), .SCK(SCK), .SDI(SDI), .SLATCH(SLATCH),
    .DATA(DATA), .VALID(VALID), .FRAME_ERR(FRAME_ERR), .ABORT(ABORT), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  // Pulse monitor: counts cycles VALID/ABORT are high, so a pulse wider than one cycle shows up.
  always @(negedge CLK) begin
    if (VALID) validCount++;
    if (ABORT) abortCount++;
    if (VALID && ABORT) overlapCount++;
  end

  task automatic waitCycles(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic sendBit(input logic b);
    SDI = b;
    waitCycles(4);
    SCK = 1'b1;
    waitCycles(4);
    SCK = 1'b0;
    waitCycles(4);
  endtask

  task automatic sendBits(input logic [15:0] bits, input int n);
    for (int i = n - 1; i >= 0; i--) sendBit(bits[i]);
  endtask

  task automatic pulseLatch();
    SLATCH = 1'b1;
    waitCycles(4);
    SLATCH = 1'b0;
    waitCycles(6);
  endtask

  task automatic test_reset();
    RSTN = 1'b0;
    waitCycles(3);
    checkCount++;
    if ({DATA, VALID, FRAME_ERR, ABORT, BUSY} !== 12'h000)
      $display("[TB] FAIL reset_outputs: got %h required 000", {DATA, VALID, FRAME_ERR, ABORT, BUSY});
    else passCount++;
    RSTN = 1'b1;
    waitCycles(2);
  endtask

  task automatic test_full_frame();
    int v0;
    v0 = validCount;
    sendBits(16'h00A5, 8);
    checkCount++;
    if (BUSY !== 1'b1) $display("[TB] FAIL a5_busy_mid: got %b required 1", BUSY);
    else passCount++;
    pulseLatch();
    checkCount++;
    if (DATA !== 8'hA5) $display("[TB] FAIL a5_data: got %h required a5", DATA);
    else passCount++;
    checkCount++;
    if (FRAME_ERR !== 1'b0) $display("[TB] FAIL a5_ferr: got %b required 0", FRAME_ERR);
    else passCount++;
    checkCount++;
    if (validCount - v0 !== 1) $display("[TB] FAIL a5_valid_cycles: got %0d required 1", validCount - v0);
    else passCount++;
    checkCount++;
    if (BUSY !== 1'b0) $display("[TB] FAIL a5_busy_end: got %b required 0", BUSY);
    else passCount++;
  endtask

  task automatic test_short_frame();
    sendBits(16'b10110, 5);
    pulseLatch();
    checkCount++;
    if (DATA !== 8'hB6) $display("[TB] FAIL short_data: got %h required b6", DATA);
    else passCount++;
    checkCount++;
    if (FRAME_ERR !== 1'b1) $display("[TB] FAIL short_ferr: got %b required 1", FRAME_ERR);
    else passCount++;
  endtask

  task automatic test_long_frame();
    sendBits(16'b11_0011_1100, 10);
    pulseLatch();
    checkCount++;
    if (DATA !== 8'h3C) $display("[TB] FAIL long_data: got %h required 3c", DATA);
    else passCount++;
    checkCount++;
    if (FRAME_ERR !== 1'b1) $display("[TB] FAIL long_ferr: got %b required 1", FRAME_ERR);
    else passCount++;
  endtask

  task automatic test_timeout();
    int v0, a0;
    v0 = validCount;
    a0 = abortCount;
    sendBits(16'b101, 3);
    checkCount++;
    if (BUSY !== 1'b1 || abortCount !== a0)
      $display("[TB] FAIL to_pre: got busy=%b aborts=%0d required busy=1 aborts=%0d", BUSY, abortCount, a0);
    else passCount++;
    waitCycles(30);
    checkCount++;
    if (abortCount - a0 !== 1) $display("[TB] FAIL to_abort_cycles: got %0d required 1", abortCount - a0);
    else passCount++;
    checkCount++;
    if (validCount !== v0) $display("[TB] FAIL to_no_valid: got %0d required %0d", validCount, v0);
    else passCount++;
    checkCount++;
    if (DATA !== 8'h3C || FRAME_ERR !== 1'b1 || BUSY !== 1'b0)
      $display("[TB] FAIL to_hold: got data=%h ferr=%b busy=%b required data=3c ferr=1 busy=0", DATA, FRAME_ERR, BUSY);
    else passCount++;
    sendBits(16'h0081, 8);
    pulseLatch();
    checkCount++;
    if (DATA !== 8'h81 || FRAME_ERR !== 1'b0)
      $display("[TB] FAIL to_recover: got data=%h ferr=%b required data=81 ferr=0", DATA, FRAME_ERR);
    else passCount++;
  endtask

  task automatic test_idle_latch();
    int v0;
    v0 = validCount;
    pulseLatch();
    checkCount++;
    if (DATA !== 8'h81 || FRAME_ERR !== 1'b1 || validCount - v0 !== 1)
      $display("[TB] FAIL idle_latch: got data=%h ferr=%b valids=%0d required data=81 ferr=1 valids=1",
               DATA, FRAME_ERR, validCount - v0);
    else passCount++;
  endtask

  task automatic test_simultaneous();
    logic [7:0] v;
    v = 8'h5B;
    for (int i = 7; i >= 1; i--) sendBit(v[i]);
    SDI = v[0];
    waitCycles(4);
    SCK = 1'b1;
    SLATCH = 1'b1;
    waitCycles(4);
    SCK = 1'b0;
    SLATCH = 1'b0;
    waitCycles(6);
    checkCount++;
    if (DATA !== 8'h5B) $display("[TB] FAIL simul_data: got %h required 5b", DATA);
    else passCount++;
    checkCount++;
    if (FRAME_ERR !== 1'b0 || BUSY !== 1'b0)
      $display("[TB] FAIL simul_ferr_busy: got ferr=%b busy=%b required 0 0", FRAME_ERR, BUSY);
    else passCount++;
  endtask

  task automatic test_reset_mid_frame();
    int v0;
    sendBits(16'b1010, 4);
    v0 = validCount;
    RSTN = 1'b0;
    waitCycles(1);
    checkCount++;
    if ({DATA, VALID, FRAME_ERR, ABORT, BUSY} !== 12'h000)
      $display("[TB] FAIL midreset_outputs: got %h required 000", {DATA, VALID, FRAME_ERR, ABORT, BUSY});
    else passCount++;
    RSTN = 1'b1;
    waitCycles(4);
    checkCount++;
    if (validCount !== v0) $display("[TB] FAIL midreset_no_valid: got %0d required %0d", validCount, v0);
    else passCount++;
    sendBits(16'h00FF, 8);
    pulseLatch();
    checkCount++;
    if (DATA !== 8'hFF || FRAME_ERR !== 1'b0)
      $display("[TB] FAIL midreset_frame: got data=%h ferr=%b required data=ff ferr=0", DATA, FRAME_ERR);
    else passCount++;
  endtask

  initial begin
    test_reset();
    test_full_frame();
    test_short_frame();
    test_long_frame();
    test_timeout();
    test_idle_latch();
    test_simultaneous();
    test_reset_mid_frame();
    checkCount++;
    if (overlapCount !== 0) $display("[TB] FAIL valid_abort_overlap: got %0d required 0", overlapCount);
    else passCount++;
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
